instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 24'h000000: byte address loaded into the PC on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 128: instruction memory depth in 24-bit words; PC range is 0 to MEM_WORDS*4-1.
REQ-003 SHALL have parameter NOP, default 24'h000000: encoding placed in the fetch/decode register on reset and on flush.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  decode not ready; hold PC and fetch/decode register.
REQ-007 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-008 SHALL have port branch_target  input  24  byte address of redirect.
REQ-009 SHALL have port instr_in  input  24  combinational read data from instruction memory at pc_out.
REQ-010 SHALL have port pc_out  output  24  current PC, byte address driven to instruction memory.
REQ-011 SHALL have port instr_out  output  24  registered instruction for decode.
REQ-012 SHALL have port pc_id  output  24  byte address of instr_out.
REQ-013 SHALL have port pc_id_plus4  output  24  pc_id+4, truncated to 24 bits, combinational from pc_id.
REQ-014 SHALL have port valid_out  output  1  instr_out holds a real fetched instruction.
REQ-015 SHALL have port fetch_count  output  16  count of instructions delivered to decode.

Function
REQ-016 SHALL drive pc_out directly from the PC register; no combinational path from any input to pc_out.
REQ-017 SHALL, when stall=0 and branch_taken=0, load pc_next = pc+4 and load instr_out<=instr_in, pc_id<=pc, valid_out<=1.
REQ-018 SHALL wrap pc_next to 0 when pc+4 >= MEM_WORDS*4 (pc = MEM_WORDS*4-4 -> 0).
REQ-019 SHALL, when branch_taken=1 (regardless of stall), load PC with {branch_target[23:2],2'b00} modulo MEM_WORDS*4, and load instr_out<=NOP, pc_id<=0, valid_out<=0 (flush).
REQ-020 SHALL, when stall=1 and branch_taken=0, hold PC, instr_out, pc_id, valid_out and fetch_count unchanged.
REQ-021 SHALL present the instruction fetched at pc_out=X on instr_out exactly one cycle later (latency 1), given no stall or branch in that cycle.
REQ-022 SHALL never silently misalign: PC bits [1:0] are always 2'b00.
REQ-023 SHALL increment fetch_count by 1 on every edge where valid_out is loaded with 1, saturating at 16'hFFFF.
REQ-024 SHALL not increment fetch_count on flush or stall cycles.
REQ-025 SHALL implement PC and fetch/decode register as one two-state control: RUN (load) and HOLD (stall); flush is a RUN-cycle variant with branch priority.

Reset
REQ-026 SHALL, while rst_n=0, immediately force pc_out=RESET_PC, instr_out=NOP, pc_id=0, valid_out=0, fetch_count=0, independent of clk.
REQ-027 SHALL, on the first rising edge after rst_n deasserts with stall=0, latch memory word at RESET_PC into instr_out with valid_out=1.
REQ-028 SHALL, if rst_n asserts mid-stall or mid-branch, discard that operation; no partial update survives.

Verification
REQ-029 Sequential fetch: reset, stall=0, branch=0 for 4 cycles -> pc_out 0,4,8,12; instr_out = mem[0..2] with pc_id 0,4,8 one cycle behind; fetch_count=3 after 3rd valid load.
REQ-030 Stall: stall=1 for 3 cycles at pc_out=8 -> pc_out, instr_out, pc_id, fetch_count unchanged; release -> pc_out 12, instr_out=mem[2].
REQ-031 Branch with stall: stall=1, branch_taken=1, branch_target=24'h000013 -> next pc_out=16'h10, valid_out=0, instr_out=NOP; next cycle instr_out=mem[4], pc_id=16'h10.
REQ-032 Wrap: run to pc_out=508 (MEM_WORDS=128) -> next pc_out=0; out-of-range target 24'h000204 -> pc_out=4.
REQ-033 Async reset: assert rst_n=0 between clock edges mid-run -> all outputs at reset values before next edge; fetch_count=0.
REQ-034 Saturation: force 65535 valid loads (or preload via long run) -> fetch_count holds 16'hFFFF on further fetches.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Single-stage instruction fetch. Holds the PC, presents it to
//               a combinational instruction memory and registers the returned
//               word into the fetch/decode register. Supports decode stalls,
//               branch redirects (flush) and counts delivered instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [23:0] RESET_PC  = 24'h000000,
    parameter int          MEM_WORDS = 128,
    parameter logic [23:0] NOP       = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [23:0] branch_target,
    input  logic [23:0] instr_in,
    output logic [23:0] pc_out,
    output logic [23:0] instr_out,
    output logic [23:0] pc_id,
    output logic [23:0] pc_id_plus4,
    output logic        valid_out,
    output logic [15:0] fetch_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Byte size of the instruction memory, one bit wider than the PC so that
    // pc+4 can be compared against it without overflow.
    localparam logic [24:0] c_mem_bytes   = 25'(MEM_WORDS * 4);
    // Reset PC is forced word aligned so the PC can never be misaligned.
    localparam logic [23:0] c_reset_pc    = RESET_PC & 24'hFFFFFC;
    localparam logic [15:0] c_count_max   = 16'hFFFF;
    localparam bit          c_mem_is_pow2 = ((MEM_WORDS & (MEM_WORDS - 1)) == 0);

    // Fetch control states: RUN loads the PC and F/D register, HOLD freezes them.
    localparam logic [0:0]  c_st_run  = 1'b0;
    localparam logic [0:0]  c_st_hold = 1'b1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [0:0]  w_state_next;

    logic        w_advance;      // sequential fetch: load PC+4 and new instruction
    logic        w_flush;        // redirect: load target PC and bubble the F/D register

    logic [23:0] r_pc;
    logic [23:0] r_instr;
    logic [23:0] r_pc_id;
    logic        r_valid;
    logic [15:0] r_fetch_count;

    logic [24:0] w_pc_plus4_wide;
    logic [23:0] w_pc_seq;
    logic [23:0] w_target_aligned;
    logic [23:0] w_target_wrapped;
    logic [23:0] w_pc_next;

    // ------------------------------------------------------------------------
    // Fetch control FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a branch always forces RUN (flush beats stall); otherwise stall selects HOLD
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_run: begin
                if (stall && !branch_taken) begin
                    w_state_next = c_st_hold;
                end else begin
                    w_state_next = c_st_run;
                end
            end
            c_st_hold: begin
                if (!stall || branch_taken) begin
                    w_state_next = c_st_run;
                end else begin
                    w_state_next = c_st_hold;
                end
            end
            default: begin
                w_state_next = c_st_run;
            end
        endcase
    end

    // Output decode: the state entered on this edge selects the datapath action
    always_comb begin
        w_advance = 1'b0;
        w_flush   = 1'b0;
        case (w_state_next)
            c_st_run: begin
                w_flush   = branch_taken;
                w_advance = !branch_taken;
            end
            c_st_hold: begin
                w_flush   = 1'b0;
                w_advance = 1'b0;
            end
            default: begin
                w_flush   = 1'b0;
                w_advance = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-PC computation
    // ------------------------------------------------------------------------

    // Sequential PC with wrap to zero at the top of instruction memory
    always_comb begin
        w_pc_plus4_wide = {1'b0, r_pc} + 25'd4;
        if (w_pc_plus4_wide >= c_mem_bytes) begin
            w_pc_seq = 24'h000000;
        end else begin
            w_pc_seq = w_pc_plus4_wide[23:0];
        end
    end

    // Branch targets are word aligned by dropping the low two bits
    assign w_target_aligned = {branch_target[23:2], 2'b00};

    // Reduce the target modulo the memory size; a mask suffices for powers of two
    generate
        if (c_mem_is_pow2) begin : g_target_mask
            localparam logic [23:0] c_addr_mask = 24'(MEM_WORDS * 4 - 1);
            assign w_target_wrapped = w_target_aligned & c_addr_mask;
        end else begin : g_target_mod
            logic [24:0] w_target_mod;
            // Memory size is a multiple of 4, so the remainder stays word aligned
            assign w_target_mod     = {1'b0, w_target_aligned} % c_mem_bytes;
            assign w_target_wrapped = w_target_mod[23:0];
        end
    endgenerate

    // Redirect has priority over sequential fetch
    always_comb begin
        w_pc_next = r_pc;
        if (w_flush) begin
            w_pc_next = w_target_wrapped;
        end else if (w_advance) begin
            w_pc_next = w_pc_seq;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------

    // Program counter; any reset mid-operation discards the pending update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= c_reset_pc;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Fetch/decode register: capture memory data on advance, bubble on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc_id <= 24'h000000;
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_instr <= NOP;
            r_pc_id <= 24'h000000;
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_instr <= instr_in;
            r_pc_id <= r_pc;
            r_valid <= 1'b1;
        end
    end

    // Delivered-instruction counter, saturating so it never wraps back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 16'h0000;
        end else if (w_advance && (r_fetch_count != c_count_max)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // pc_out comes straight from the register so memory address timing is clean
    assign pc_out      = r_pc;
    assign instr_out   = r_instr;
    assign pc_id       = r_pc_id;
    assign pc_id_plus4 = r_pc_id + 24'd4;
    assign valid_out   = r_valid;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch with a
//               combinational instruction memory model (mem[i] = 0x100000+i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int          c_mem_words = 128;
    localparam logic [23:0] c_nop       = 24'h000000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [23:0] branch_target;
    logic [23:0] instr_in;
    logic [23:0] pc_out;
    logic [23:0] instr_out;
    logic [23:0] pc_id;
    logic [23:0] pc_id_plus4;
    logic        valid_out;
    logic [15:0] fetch_count;

    logic [23:0] mem [0:c_mem_words-1];

    int n_vec;
    int n_err;

    instruction_fetch #(
        .RESET_PC  (24'h000000),
        .MEM_WORDS (c_mem_words),
        .NOP       (c_nop)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .pc_id         (pc_id),
        .pc_id_plus4   (pc_id_plus4),
        .valid_out     (valid_out),
        .fetch_count   (fetch_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory addressed by the word part of pc_out
    always_comb begin
        instr_in = mem[pc_out[8:2]];
    end

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state in one go
    task automatic check_all(input string tag, input logic [23:0] e_pc, input logic [23:0] e_instr,
                             input logic [23:0] e_pc_id, input logic e_valid, input logic [15:0] e_cnt);
        check({tag, ".pc_out"},    pc_out,               e_pc);
        check({tag, ".instr_out"}, instr_out,            e_instr);
        check({tag, ".pc_id"},     pc_id,                e_pc_id);
        check({tag, ".valid"},     {23'd0, valid_out},   {23'd0, e_valid});
        check({tag, ".count"},     {8'd0, fetch_count},  {8'd0, e_cnt});
    endtask

    // Watchdog: the run is cycle-counted, this only guards against a stuck simulator
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < c_mem_words; i++) begin
            mem[i] = 24'h100000 + 24'(i);
        end
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 24'h000000;

        // Reset values, observed before any clock edge
        #2;
        check_all("reset", 24'h000000, c_nop, 24'h000000, 1'b0, 16'd0);
        check("reset.plus4", pc_id_plus4, 24'h000004);

        // Release reset away from the edge
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch: one-cycle latency from pc_out to instr_out
        step();
        check_all("seq1", 24'h000004, 24'h100000, 24'h000000, 1'b1, 16'd1);
        step();
        check_all("seq2", 24'h000008, 24'h100001, 24'h000004, 1'b1, 16'd2);

        // Stall three cycles at pc_out=8: everything frozen
        stall = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check_all("stall", 24'h000008, 24'h100001, 24'h000004, 1'b1, 16'd2);
        stall = 1'b0;
        step();
        check_all("unstall", 24'h00000C, 24'h100002, 24'h000008, 1'b1, 16'd3);
        check("unstall.plus4", pc_id_plus4, 24'h00000C);

        // Branch while stalled: branch wins, target aligned 0x13 -> 0x10, F/D flushed
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 24'h000013;
        step();
        check_all("brstall", 24'h000010, c_nop, 24'h000000, 1'b0, 16'd3);
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        check_all("brnext", 24'h000014, 24'h100004, 24'h000010, 1'b1, 16'd4);

        // Jump near the top of memory and wrap
        branch_taken  = 1'b1;
        branch_target = 24'h0001F8;
        step();
        check_all("brtop", 24'h0001F8, c_nop, 24'h000000, 1'b0, 16'd4);
        branch_taken = 1'b0;
        step();
        check_all("top508", 24'h0001FC, 24'h10007E, 24'h0001F8, 1'b1, 16'd5);
        step();
        check_all("wrap", 24'h000000, 24'h10007F, 24'h0001FC, 1'b1, 16'd6);
        check("wrap.plus4", pc_id_plus4, 24'h000200);

        // Out-of-range target reduced modulo memory size: 0x204 -> 0x004
        branch_taken  = 1'b1;
        branch_target = 24'h000204;
        step();
        check("oor.pc", pc_out, 24'h000004);
        branch_taken = 1'b0;
        step();
        check_all("oornext", 24'h000008, 24'h100001, 24'h000004, 1'b1, 16'd7);

        // Asynchronous reset between edges takes effect before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all("areset", 24'h000000, c_nop, 24'h000000, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("arelease", 24'h000004, 24'h100000, 24'h000000, 1'b1, 16'd1);

        // Reset asserted over a pending stalled branch: branch is discarded
        @(negedge clk);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 24'h000040;
        rst_n         = 1'b0;
        step();
        check_all("rstbr", 24'h000000, c_nop, 24'h000000, 1'b0, 16'd0);
        @(negedge clk);
        stall        = 1'b0;
        branch_taken = 1'b0;
        rst_n        = 1'b1;

        // Saturation: 65534 loads, then reach and hold 0xFFFF
        for (int k = 0; k < 65534; k++) step();
        check("sat.fffe", {8'd0, fetch_count}, 24'h00FFFE);
        step();
        check("sat.ffff", {8'd0, fetch_count}, 24'h00FFFF);
        step();
        step();
        check("sat.hold", {8'd0, fetch_count}, 24'h00FFFF);
        check("sat.valid", {23'd0, valid_out}, 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
